// File: rtl/ray_march_ctrl_pkg.sv
// Q16.16 signed fixed-point vector types, saturating arithmetic helpers,
// default march thresholds and the controller state encoding.
package ray_march_ctrl_pkg;

   localparam int FP_W    = 32;
   localparam int FP_FRAC = 16;

   typedef logic signed [FP_W-1:0] fp_t;

   typedef struct packed {
      fp_t x;
      fp_t y;
      fp_t z;
   } vec3_t;

   localparam fp_t FP_MAX      = {1'b0, {(FP_W-1){1'b1}}};
   localparam fp_t FP_MIN      = {1'b1, {(FP_W-1){1'b0}}};
   // 0.001 rounds to 66 LSBs; 20.0 is exact
   localparam fp_t FP_HIT_EPS  = fp_t'(66);
   localparam fp_t FP_MAX_DIST = fp_t'(20 <<< FP_FRAC);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_UPDATE,
      ST_DONE
   } march_state_t;

   function automatic fp_t fp_sat_wide(input logic signed [2*FP_W-1:0] v);
      if (v > FP_MAX)
         return FP_MAX;
      else if (v < FP_MIN)
         return FP_MIN;
      else
         return v[FP_W-1:0];
   endfunction

   function automatic fp_t fp_mul(input fp_t a, input fp_t b);
      logic signed [2*FP_W-1:0] aw;
      logic signed [2*FP_W-1:0] bw;
      logic signed [2*FP_W-1:0] p;
      aw = a;
      bw = b;
      p  = (aw * bw) >>> FP_FRAC;
      return fp_sat_wide(p);
   endfunction

   function automatic fp_t fp_add_sat(input fp_t a, input fp_t b);
      logic signed [FP_W:0] s;
      s = {a[FP_W-1], a} + {b[FP_W-1], b};
      if (s[FP_W] != s[FP_W-1])
         return s[FP_W] ? FP_MIN : FP_MAX;
      return s[FP_W-1:0];
   endfunction

endpackage

// File: rtl/ray_march_ctrl_point.sv
// Combinational ray evaluation: point = origin + dir * t, with every
// component saturating. Also usable by the shading stage.
module ray_point_eval
   import ray_march_ctrl_pkg::*;
(
   input  vec3_t origin,
   input  vec3_t dir,
   input  fp_t   t,
   output vec3_t point
);

   always_comb begin
      point.x = fp_add_sat(origin.x, fp_mul(dir.x, t));
      point.y = fp_add_sat(origin.y, fp_mul(dir.y, t));
      point.z = fp_add_sat(origin.z, fp_mul(dir.z, t));
   end

endmodule

// File: rtl/ray_march_ctrl.sv
// Sphere-tracing controller: issues SDF samples along a ray and advances by
// each returned distance. Optional watchdog abort under SDF_WATCHDOG_EN.
module ray_march_ctrl
   import ray_march_ctrl_pkg::*;
#(
   parameter int  MAX_STEPS = 64,
   parameter int  STEP_W    = 7,
   parameter fp_t HIT_EPS   = FP_HIT_EPS,
   parameter fp_t MAX_DIST  = FP_MAX_DIST
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  vec3_t             ray_origin,
   input  vec3_t             ray_dir,
   output logic              ready,
   output vec3_t             sdf_point,
   output logic              sdf_valid,
   input  fp_t               sdf_dist,
   input  logic              sdf_dist_valid,
   output logic              done,
   output logic              hit,
   output fp_t               t_out,
   output logic [STEP_W-1:0] steps_out,
   output logic              error
);

   march_state_t      state, state_nxt;
   logic [STEP_W-1:0] steps_r;
   vec3_t             origin_r, dir_r;
   fp_t               t_r, d_r, t_plus_d;
   vec3_t             next_point;
   logic              is_hit, is_far, is_limit, wd_expired;

   assign t_plus_d = fp_add_sat(t_r, d_r);
   assign is_hit   = d_r < HIT_EPS;
   assign is_far   = t_plus_d > MAX_DIST;
   assign is_limit = steps_r == STEP_W'(MAX_STEPS);

   ray_point_eval u_point (
      .origin (origin_r),
      .dir    (dir_r),
      .t      (t_plus_d),
      .point  (next_point)
   );

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      sdf_valid = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            ready = 1'b1;
            if (start) state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            sdf_valid = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (sdf_dist_valid)  state_nxt = ST_UPDATE;
            else if (wd_expired) state_nxt = ST_DONE;
         end
         ST_UPDATE: state_nxt = (is_hit || is_far || is_limit) ? ST_DONE : ST_ISSUE;
         ST_DONE:   begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         steps_r   <= '0;
         hit       <= 1'b0;
         t_out     <= '0;
         steps_out <= '0;
         sdf_point <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: if (start) begin
               steps_r   <= '0;
               sdf_point <= ray_origin;
            end
            ST_WAIT: begin
               if (sdf_dist_valid) begin
                  steps_r <= steps_r + STEP_W'(1);
               end else if (wd_expired) begin
                  hit       <= 1'b0;
                  t_out     <= t_r;
                  steps_out <= steps_r;
               end
            end
            ST_UPDATE: begin
               // hit wins over far-plane, far-plane wins over step limit
               if (is_hit) begin
                  hit       <= 1'b1;
                  t_out     <= t_r;
                  steps_out <= steps_r;
               end else if (is_far) begin
                  hit       <= 1'b0;
                  t_out     <= MAX_DIST;
                  steps_out <= steps_r;
               end else if (is_limit) begin
                  hit       <= 1'b0;
                  t_out     <= t_plus_d;
                  steps_out <= steps_r;
               end else begin
                  sdf_point <= next_point;
               end
            end
            default: ;
         endcase
      end
   end

   // Ray data only matters after an accept, so it carries no reset.
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && start) begin
         origin_r <= ray_origin;
         dir_r    <= ray_dir;
         t_r      <= '0;
      end else if (state == ST_UPDATE && !(is_hit || is_far || is_limit)) begin
         t_r <= t_plus_d;
      end
      if (state == ST_WAIT && sdf_dist_valid)
         d_r <= sdf_dist;
   end

`ifdef SDF_WATCHDOG_EN
   logic [3:0] wd_cnt;

   // Abort at the end of the 15th silent WAIT cycle.
   assign wd_expired = (state == ST_WAIT) && !sdf_dist_valid && (wd_cnt == 4'd14);

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt <= '0;
         error  <= 1'b0;
      end else begin
         if (state == ST_WAIT && !sdf_dist_valid)
            wd_cnt <= wd_cnt + 4'd1;
         else
            wd_cnt <= '0;
         if (state == ST_IDLE && start)
            error <= 1'b0;
         else if (wd_expired)
            error <= 1'b1;
      end
   end
`else
   assign wd_expired = 1'b0;
   assign error      = 1'b0;
`endif

endmodule
